// File: rtl/leaf_pkg.sv
// Shared constants and helpers for the leaf user-side merge stage.
package leaf_pkg;

  localparam int PAYLOAD_BITS_DEF = 32;
  localparam int ARB_RR           = 0;
  localparam int ARB_PRIO         = 1;

  // Smallest p with 2**p >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 0; p < 31; p++) begin
      if ((1 << p) < value) begin
        result = p + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/leaf_user_arbiter_if.sv
// Bundle of the user-side channels and the merged leaf-side output of leaf_user_arbiter.
interface leaf_user_arbiter_if
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int NUM_CH       = 4,
  parameter int CH_BITS      = 2
);

  logic [NUM_CH*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_CH-1:0]              vld_user;
  logic [NUM_CH-1:0]              ack_user;
  logic [PAYLOAD_BITS-1:0]        dout;
  logic [CH_BITS-1:0]             dout_port;
  logic                           vld_out;
  logic                           ack_in;
  logic [NUM_CH-1:0]              fifo_full;

  modport master (
    output din_user, vld_user, ack_in,
    input  ack_user, dout, dout_port, vld_out, fifo_full
  );

  modport slave (
    input  din_user, vld_user, ack_in,
    output ack_user, dout, dout_port, vld_out, fifo_full
  );

endinterface

// File: rtl/leaf_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest word while not empty.
module leaf_sync_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    rd_en,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    full,
  output logic                    empty
);

  logic [PAYLOAD_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
  logic [FIFO_ADDR_BITS:0]   r_count;
  logic                      w_wr;
  logic                      w_rd;

  assign full  = (r_count == (FIFO_ADDR_BITS+1)'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  // A full FIFO refuses writes even when it is popped in the same cycle.
  assign w_wr  = wr_en & ~full;
  assign w_rd  = rd_en & ~empty;
  assign dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_user_arbiter.sv
// Merges NUM_CH ap_vld/ap_ack user streams through per-channel FIFOs onto one
// tagged output register, using round-robin or fixed-priority arbitration.
module leaf_user_arbiter
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int NUM_CH         = 4,
  parameter int CH_BITS        = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_BITS = 2,
  parameter int MODE_PRIORITY  = ARB_RR
) (
  input  logic               clk_user,
  input  logic               reset,
  leaf_user_arbiter_if.slave bus
);

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("leaf_user_arbiter: NUM_CH must be within 2..16");
  end
  if (CH_BITS < clog2(NUM_CH)) begin : g_bad_ch_bits
    $error("leaf_user_arbiter: CH_BITS too narrow for NUM_CH");
  end
  if (FIFO_DEPTH < 2 || FIFO_ADDR_BITS != clog2(FIFO_DEPTH)
      || (1 << FIFO_ADDR_BITS) != FIFO_DEPTH) begin : g_bad_fifo
    $error("leaf_user_arbiter: FIFO_DEPTH must be a power of two >= 2 matching FIFO_ADDR_BITS");
  end

  logic [NUM_CH-1:0]       w_full;
  logic [NUM_CH-1:0]       w_empty;
  logic [NUM_CH-1:0]       w_ack;
  logic [NUM_CH-1:0]       w_wr_en;
  logic [NUM_CH-1:0]       w_rd_en;
  logic [PAYLOAD_BITS-1:0] w_fifo_dout [NUM_CH];

  logic                    w_load;
  logic                    w_grant_vld;
  logic [CH_BITS-1:0]      w_grant;
  logic [PAYLOAD_BITS-1:0] w_grant_data;
  int                      w_best;
  int                      w_dist;

  logic [PAYLOAD_BITS-1:0] r_dout;
  logic [CH_BITS-1:0]      r_port;
  logic                    r_vld;
  logic [CH_BITS-1:0]      r_rr_ptr;

  assign w_ack = ~w_full & {NUM_CH{~reset}};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_wr_en[gi] = bus.vld_user[gi] & w_ack[gi];
    assign w_rd_en[gi] = w_load & w_grant_vld & (w_grant == CH_BITS'(gi));

    leaf_sync_fifo #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
      .clk   (clk_user),
      .rst   (reset),
      .wr_en (w_wr_en[gi]),
      .din   (bus.din_user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_en (w_rd_en[gi]),
      .dout  (w_fifo_dout[gi]),
      .full  (w_full[gi]),
      .empty (w_empty[gi])
    );
  end

  // Output register may take a new word when empty or being drained this edge.
  assign w_load = ~r_vld | bus.ack_in;

  // Winner is the non-empty channel at the smallest search distance from the start point.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant      = '0;
    w_grant_data = '0;
    w_best       = NUM_CH;
    w_dist       = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (MODE_PRIORITY == ARB_PRIO) begin
        w_dist = ch;
      end else if (ch >= int'(r_rr_ptr)) begin
        w_dist = ch - int'(r_rr_ptr);
      end else begin
        w_dist = ch + NUM_CH - int'(r_rr_ptr);
      end
      if (!w_empty[ch] && w_dist < w_best) begin
        w_best       = w_dist;
        w_grant_vld  = 1'b1;
        w_grant      = CH_BITS'(ch);
        w_grant_data = w_fifo_dout[ch];
      end
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      r_dout   <= '0;
      r_port   <= '0;
      r_vld    <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_dout <= w_grant_data;
        r_port <= w_grant;
        if (MODE_PRIORITY == ARB_RR) begin
          r_rr_ptr <= (w_grant == CH_BITS'(NUM_CH-1)) ? '0 : w_grant + CH_BITS'(1);
        end
      end
    end
  end

  assign bus.ack_user  = w_ack;
  assign bus.fifo_full = w_full;
  assign bus.dout      = r_dout;
  assign bus.dout_port = r_port;
  assign bus.vld_out   = r_vld;

endmodule

// File: tb/tb_leaf_user_arbiter.sv
// Drives a round-robin and a fixed-priority leaf_user_arbiter with shared-style
// traffic and checks both against a queue-based model every cycle.
module tb_leaf_user_arbiter;
  import leaf_pkg::*;

  localparam int PB  = 32;
  localparam int NC  = 4;
  localparam int CB  = 2;
  localparam int FD  = 4;
  localparam int FAB = 2;
  localparam int NI  = 2;   // instance 0: round-robin, instance 1: fixed priority

  typedef struct {
    int              cyc;
    int              port;
    logic [PB-1:0]   data;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  leaf_user_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_CH(NC), .CH_BITS(CB)) bus_rr ();
  leaf_user_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_CH(NC), .CH_BITS(CB)) bus_pr ();

  leaf_user_arbiter #(.PAYLOAD_BITS(PB), .NUM_CH(NC), .CH_BITS(CB), .FIFO_DEPTH(FD),
                      .FIFO_ADDR_BITS(FAB), .MODE_PRIORITY(ARB_RR))
    dut_rr (.clk_user(clk), .reset(reset), .bus(bus_rr.slave));
  leaf_user_arbiter #(.PAYLOAD_BITS(PB), .NUM_CH(NC), .CH_BITS(CB), .FIFO_DEPTH(FD),
                      .FIFO_ADDR_BITS(FAB), .MODE_PRIORITY(ARB_PRIO))
    dut_pr (.clk_user(clk), .reset(reset), .bus(bus_pr.slave));

  logic [PB-1:0] drv_data [NI][NC];
  logic [NC-1:0] drv_vld  [NI];
  logic          drv_ack_in [NI];
  logic [NC-1:0] mon_ack  [NI];
  logic [NC-1:0] mon_full [NI];
  logic [PB-1:0] mon_dout [NI];
  logic [CB-1:0] mon_port [NI];
  logic          mon_vld  [NI];

  for (genvar gi = 0; gi < NC; gi++) begin : g_din
    assign bus_rr.din_user[gi*PB +: PB] = drv_data[0][gi];
    assign bus_pr.din_user[gi*PB +: PB] = drv_data[1][gi];
  end
  assign bus_rr.vld_user = drv_vld[0];
  assign bus_pr.vld_user = drv_vld[1];
  assign bus_rr.ack_in   = drv_ack_in[0];
  assign bus_pr.ack_in   = drv_ack_in[1];
  assign mon_ack[0]  = bus_rr.ack_user;   assign mon_ack[1]  = bus_pr.ack_user;
  assign mon_full[0] = bus_rr.fifo_full;  assign mon_full[1] = bus_pr.fifo_full;
  assign mon_dout[0] = bus_rr.dout;       assign mon_dout[1] = bus_pr.dout;
  assign mon_port[0] = bus_rr.dout_port;  assign mon_port[1] = bus_pr.dout_port;
  assign mon_vld[0]  = bus_rr.vld_out;    assign mon_vld[1]  = bus_pr.vld_out;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int vld_pct = 100;
  int ack_pct = 100;

  logic [PB-1:0] send_q [NI][NC][$];
  logic [NC-1:0] ack_seen [NI];
  ev_t           out_log [NI][$];
  ev_t           acc_log [NI][$];

  // Reference model: word queues per channel plus one output slot per instance.
  logic [PB-1:0] mq [NI][NC][$];
  logic          m_ov [NI] = '{1'b0, 1'b0};
  logic [PB-1:0] m_od [NI] = '{'0, '0};
  int            m_op [NI] = '{0, 0};
  int            m_rr [NI] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit bench_idle();
    bit idle;
    idle = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (m_ov[i] || mon_vld[i]) idle = 1'b0;
      for (int c = 0; c < NC; c++) begin
        if (send_q[i][c].size() != 0 || drv_vld[i][c] || mq[i][c].size() != 0) idle = 1'b0;
      end
    end
    return idle;
  endfunction

  task automatic wait_idle(input string name, input int max_cyc);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < max_cyc && !idle; n++) begin
      @(negedge clk);
      idle = bench_idle();
    end
    chk(name, {63'd0, idle}, 64'd1);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NI; i++) begin
      drv_vld[i] = '0;
      for (int c = 0; c < NC; c++) send_q[i][c].delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    clear_stim();
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      out_log[i].delete();
      acc_log[i].delete();
    end
  endtask

  task automatic push_both(input int ch, input logic [PB-1:0] word);
    for (int i = 0; i < NI; i++) send_q[i][ch].push_back(word);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Producers and leaf-side acceptor; a producer holds its word until ack was seen.
  initial begin : driver
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < NC; c++) begin
          if (drv_vld[i][c] && ack_seen[i][c]) begin
            acc_log[i].push_back('{cyc, c, drv_data[i][c]});
            void'(send_q[i][c].pop_front());
            drv_vld[i][c] = 1'b0;
          end
          if (!drv_vld[i][c] && send_q[i][c].size() > 0
              && int'($urandom_range(99)) < vld_pct) begin
            drv_vld[i][c]  = 1'b1;
            drv_data[i][c] = send_q[i][c][0];
          end
        end
        drv_ack_in[i] = (int'($urandom_range(99)) < ack_pct);
      end
    end
  end

  initial begin : model
    bit            load;
    bit            found;
    int            c;
    bit [NC-1:0]   was_full;
    forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < NI; i++) begin
        if (reset) begin
          for (int k = 0; k < NC; k++) mq[i][k].delete();
          m_ov[i] = 1'b0; m_od[i] = '0; m_op[i] = 0; m_rr[i] = 0;
        end else begin
          load = !m_ov[i] || drv_ack_in[i];
          for (int k = 0; k < NC; k++) was_full[k] = (mq[i][k].size() >= FD);
          if (load) begin
            found = 1'b0;
            for (int k = 0; k < NC; k++) begin
              c = (i == 1) ? k : (m_rr[i] + k) % NC;
              if (!found && mq[i][c].size() > 0) begin
                found   = 1'b1;
                m_od[i] = mq[i][c].pop_front();
                m_op[i] = c;
                if (i == 0) m_rr[i] = (c + 1) % NC;
              end
            end
            m_ov[i] = found;
          end
          for (int k = 0; k < NC; k++) begin
            if (drv_vld[i][k] && !was_full[k]) mq[i][k].push_back(drv_data[i][k]);
          end
        end
      end
    end
  end

  initial begin : compare
    logic [NC-1:0] exp_ack;
    logic [NC-1:0] exp_full;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < NC; k++) begin
          exp_full[k] = (mq[i][k].size() == FD);
          exp_ack[k]  = !reset && (mq[i][k].size() < FD);
        end
        chk($sformatf("ack_user[%0d]", i), 64'(mon_ack[i]), 64'(exp_ack));
        chk($sformatf("fifo_full[%0d]", i), 64'(mon_full[i]), 64'(exp_full));
        chk($sformatf("vld_out[%0d]", i), 64'(mon_vld[i]), 64'(m_ov[i]));
        if (m_ov[i]) begin
          chk($sformatf("dout[%0d]", i), 64'(mon_dout[i]), 64'(m_od[i]));
          chk($sformatf("dout_port[%0d]", i), 64'(mon_port[i]), 64'(m_op[i]));
        end
        if (reset) begin
          chk($sformatf("dout_rst[%0d]", i), 64'(mon_dout[i]), 64'd0);
          chk($sformatf("port_rst[%0d]", i), 64'(mon_port[i]), 64'd0);
        end
        ack_seen[i] = mon_ack[i];
        if (!reset && mon_vld[i] && drv_ack_in[i]) begin
          out_log[i].push_back('{cyc, int'(mon_port[i]), mon_dout[i]});
        end
      end
    end
  end

  initial begin : main
    int n_sent;
    for (int i = 0; i < NI; i++) begin
      drv_vld[i]    = '0;
      drv_ack_in[i] = 1'b1;
      ack_seen[i]   = '0;
      for (int c = 0; c < NC; c++) drv_data[i][c] = '0;
    end

    // Reset held, then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_ack_in_reset", 64'(mon_ack[0]), 64'h0);
    chk("t1_vld_in_reset", 64'(mon_vld[0]), 64'h0);
    chk("t1_dout_in_reset", 64'(mon_dout[0]), 64'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t1_ack_after_release", 64'(mon_ack[0]), 64'hF);
    chk("t1_full_after_release", 64'(mon_full[1]), 64'h0);

    // Two back-to-back words on channel 2
    do_reset();
    vld_pct = 100; ack_pct = 100;
    @(negedge clk);
    push_both(2, 32'hA5A5_0001);
    push_both(2, 32'hA5A5_0002);
    wait_idle("t2_drain", 50);
    chk("t2_count", 64'(out_log[0].size()), 64'd2);
    if (out_log[0].size() >= 2 && acc_log[0].size() >= 1) begin
      chk("t2_word0", 64'(out_log[0][0].data), 64'hA5A5_0001);
      chk("t2_port0", 64'(out_log[0][0].port), 64'd2);
      chk("t2_word1", 64'(out_log[0][1].data), 64'hA5A5_0002);
      chk("t2_latency", 64'(out_log[0][0].cyc - acc_log[0][0].cyc), 64'd1);
      chk("t2_no_bubble", 64'(out_log[0][1].cyc - out_log[0][0].cyc), 64'd1);
    end

    // All channels streaming, round-robin order
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < NC; c++) push_both(c, 32'hC000_0000 | (c << 8) | k);
    wait_idle("t3_drain", 200);
    chk("t3_count", 64'(out_log[0].size()), 64'd24);
    for (int k = 0; k < 24 && k < out_log[0].size(); k++) begin
      chk($sformatf("t3_port%0d", k), 64'(out_log[0][k].port), 64'(k % NC));
      chk($sformatf("t3_data%0d", k), 64'(out_log[0][k].data),
          64'(32'hC000_0000 | ((k % NC) << 8) | (k / NC)));
      chk($sformatf("t3_cycle%0d", k), 64'(out_log[0][k].cyc - out_log[0][0].cyc), 64'(k));
    end

    // Stall: channel 1 fills FIFO plus output register
    do_reset();
    ack_pct = 0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) push_both(1, 32'h10 + k);
    repeat (15) @(negedge clk);
    chk("t4_accepted", 64'(acc_log[0].size()), 64'd5);
    chk("t4_ack1_low", 64'(mon_ack[0][1]), 64'd0);
    chk("t4_full1", 64'(mon_full[0][1]), 64'd1);
    chk("t4_vld_held", 64'(mon_vld[0]), 64'd1);
    chk("t4_dout_held", 64'(mon_dout[0]), 64'h10);
    ack_pct = 100;
    wait_idle("t4_drain", 200);
    chk("t4_count", 64'(out_log[0].size()), 64'd16);
    for (int k = 0; k < 16 && k < out_log[0].size(); k++)
      chk($sformatf("t4_data%0d", k), 64'(out_log[0][k].data), 64'(32'h10 + k));

    // Fixed priority: channel 0 drains completely before channel 3
    do_reset();
    ack_pct = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_both(0, 32'h5000_0000 + k);
      push_both(3, 32'h5300_0000 + k);
    end
    repeat (10) @(negedge clk);
    ack_pct = 100;
    wait_idle("t5_drain", 100);
    chk("t5_count", 64'(out_log[1].size()), 64'd8);
    for (int k = 0; k < 8 && k < out_log[1].size(); k++) begin
      chk($sformatf("t5_port%0d", k), 64'(out_log[1][k].port), (k < 4) ? 64'd0 : 64'd3);
      chk($sformatf("t5_data%0d", k), 64'(out_log[1][k].data),
          (k < 4) ? 64'(32'h5000_0000 + k) : 64'(32'h5300_0000 + k - 4));
    end

    // Reset mid-stream discards buffered words
    do_reset();
    ack_pct = 0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) push_both(c, 32'h6000_0000 + c);
    repeat (6) @(negedge clk);
    chk("t6_vld_before", 64'(mon_vld[0]), 64'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    clear_stim();
    #1;
    chk("t6_vld_rr_async", 64'(mon_vld[0]), 64'd0);
    chk("t6_vld_pr_async", 64'(mon_vld[1]), 64'd0);
    chk("t6_ack_async", 64'(mon_ack[0]), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < NI; i++) begin out_log[i].delete(); acc_log[i].delete(); end
    ack_pct = 100;
    @(negedge clk);
    push_both(0, 32'hDEAD_BEEF);
    wait_idle("t6_drain", 50);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("t6_count[%0d]", i), 64'(out_log[i].size()), 64'd1);
      if (out_log[i].size() >= 1) begin
        chk($sformatf("t6_data[%0d]", i), 64'(out_log[i][0].data), 64'hDEAD_BEEF);
        chk($sformatf("t6_port[%0d]", i), 64'(out_log[i][0].port), 64'd0);
      end
    end

    // Randomised traffic with random valid gaps and back-pressure
    do_reset();
    vld_pct = 60; ack_pct = 70;
    n_sent = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(3) == 0) begin
          push_both(c, $urandom);
          n_sent++;
        end
      end
    end
    vld_pct = 100; ack_pct = 100;
    wait_idle("rand_drain", 600);
    chk("rand_count_rr", 64'(out_log[0].size()), 64'(n_sent));
    chk("rand_count_pr", 64'(out_log[1].size()), 64'(n_sent));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
